// File: rtl/uart_rx_deframer_if.sv
// Receive-side bundle of uart_rx_deframer: byte strobe, status flags, byte count
// and a debug view of the receive FSM state.
interface uart_rx_deframer_if;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_running;
    logic       rx_framing_error;
    logic       rx_break;
    logic [7:0] num_bytes_received;
    logic [2:0] state_dbg;

    // rx_data_valid and rx_framing_error are single-cycle strobes with no ready:
    // the consumer must take rx_data in the cycle rx_data_valid is high.
    modport master (
        output rx_data, rx_data_valid, rx_running, rx_framing_error,
               rx_break, num_bytes_received, state_dbg
    );
    modport slave (
        input rx_data, rx_data_valid, rx_running, rx_framing_error,
              rx_break, num_bytes_received, state_dbg
    );
endinterface

// File: rtl/uart_rx_deframer.sv
// 8N1 UART receiver: synchronises uart_rx, majority-samples each bit at its
// centre, and emits byte strobes, framing-error pulses and a break level.
module uart_rx_deframer #(
    parameter int unsigned UART_CLK_TICKS_PER_BIT = 7'd65,
    parameter int unsigned UART_CLK_TICKS_WIDTH   = 7
) (
    input  logic clk_in,
    input  logic reset,
    input  logic uart_rx,
    uart_rx_deframer_if.master rx_if
);
    localparam int unsigned TW = UART_CLK_TICKS_WIDTH;
    localparam logic [TW-1:0] HALF     = TW'(UART_CLK_TICKS_PER_BIT >> 1);
    localparam logic [TW-1:0] LAST     = TW'(UART_CLK_TICKS_PER_BIT - 1);
    localparam logic [TW-1:0] TICK_ONE = TW'(1);

    typedef enum logic [2:0] {
        WAIT_IDLE = 3'd0,
        IDLE      = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        STOP      = 3'd4
    } state_t;

    state_t        state, state_d;
    logic          rx_meta, rxs;
    logic [1:0]    hist;
    logic [TW-1:0] tick, tick_d;
    logic [2:0]    bit_idx, bit_idx_d;
    logic [7:0]    shift, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          brk_q, brk_d;
    logic          run_q, run_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          maj;

    // hist holds rxs from the previous two cycles, so at a sample point S the
    // vote covers tick S-2, S-1 and S.
    assign maj = (hist[1] & hist[0]) | (hist[1] & rxs) | (hist[0] & rxs);

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            hist    <= 2'b11;
            state   <= WAIT_IDLE;
            tick    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            brk_q   <= 1'b0;
            run_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            rx_meta <= uart_rx;
            rxs     <= rx_meta;
            hist    <= {hist[0], rxs};
            state   <= state_d;
            tick    <= tick_d;
            bit_idx <= bit_idx_d;
            shift   <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            brk_q   <= brk_d;
            run_q   <= run_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state;
        tick_d    = tick + TICK_ONE;
        bit_idx_d = bit_idx;
        shift_d   = shift;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        brk_d     = brk_q;
        run_d     = run_q;
        cnt_d     = cnt_q;
        case (state)
            WAIT_IDLE: begin
                if (rxs) begin
                    state_d = IDLE;
                    brk_d   = 1'b0;
                end
            end
            IDLE: begin
                if (!rxs) begin
                    state_d = START;
                    tick_d  = '0;
                    run_d   = 1'b1;
                end
            end
            START: begin
                if (tick == HALF) begin
                    tick_d = '0;
                    if (!maj) begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end else begin
                        // Start bit did not hold low to its centre: treat as a glitch.
                        state_d = IDLE;
                        run_d   = 1'b0;
                    end
                end
            end
            DATA: begin
                if (tick == LAST) begin
                    tick_d    = '0;
                    shift_d   = {maj, shift[7:1]};
                    bit_idx_d = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (tick == LAST) begin
                    tick_d = '0;
                    run_d  = 1'b0;
                    if (maj) begin
                        data_d  = shift;
                        valid_d = 1'b1;
                        cnt_d   = cnt_q + 8'd1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        if (shift == 8'h00) brk_d = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    assign rx_if.rx_data            = data_q;
    assign rx_if.rx_data_valid      = valid_q;
    assign rx_if.rx_running         = run_q;
    assign rx_if.rx_framing_error   = ferr_q;
    assign rx_if.rx_break           = brk_q;
    assign rx_if.num_bytes_received = cnt_q;
    assign rx_if.state_dbg          = state;
endmodule

// File: doc/uart_rx_deframer.md
# uart_rx_deframer

Serial byte receiver that sits directly upstream of `control_module`. It converts the raw `uart_rx` line (8N1, LSB first, idle high) into byte strobes for the command parser. It synchronises the line and validates the start bit. Each bit is sampled at its centre with a 3-sample majority vote. Framing errors and line-break conditions are flagged, and accepted bytes are counted.

## Interface
- `UART_CLK_TICKS_PER_BIT`, default 7'd65: clk_in ticks per bit (16 MHz / 246154 baud). Must be ≥ 8.
- `UART_CLK_TICKS_WIDTH`, default 7: width of the bit-tick counter.
- `clk_in`  input  1  sole clock; all state is on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `uart_rx`  input  1  asynchronous serial line; idle high.
- `rx_data`  output  8  last accepted byte; holds its value between strobes.
- `rx_data_valid`  output  1  one-cycle pulse; `rx_data` is valid in the same cycle.
- `rx_running`  output  1  high from start-edge detection until the FSM leaves STOP.
- `rx_framing_error`  output  1  one-cycle pulse when the stop bit samples low.
- `rx_break`  output  1  level; high while a break condition persists.
- `num_bytes_received`  output  8  count of accepted bytes; wraps 255 → 0.

## Operation
- Synchroniser: 2 flops on `uart_rx`, both reset to 1. The FSM uses only the synchronised line `rxs`.
- Constants: HALF = UART_CLK_TICKS_PER_BIT >> 1 (32 at default). Counter `tick` has width UART_CLK_TICKS_WIDTH.
- Majority sample: the sampled value is the majority of `rxs` at tick = S-2, S-1 and S, where S is the sample point.
- States:
  - WAIT_IDLE: entered from reset and after a break or framing error. Moves to IDLE in the cycle `rxs`=1 is seen.
  - IDLE: when `rxs`=0, moves to START, clears `tick` and sets `rx_running`.
  - START: sample point tick=HALF. Sample 0 → DATA with `tick` cleared and bit index 0. Sample 1 → glitch: back to IDLE, `rx_running` cleared, no other output.
  - DATA: sample point tick=UART_CLK_TICKS_PER_BIT-1. Shift the sample into the shift register MSB and right-shift (LSB first). After the 8th bit go to STOP.
  - STOP: sample point tick=UART_CLK_TICKS_PER_BIT-1.
    - Sample 1: `rx_data` ← shift register, pulse `rx_data_valid`, increment the count, go to IDLE.
    - Sample 0: pulse `rx_framing_error`; `rx_data` and the count are unchanged. If the shift register is 0x00, also set `rx_break`. Go to WAIT_IDLE.
- `rx_break` clears in the cycle WAIT_IDLE sees `rxs`=1.
- `rx_running` clears in the same cycle as the valid or error pulse.
- Arithmetic: `tick` increments by 1 and is cleared at each sample point. The count is a plain 8-bit wrap.

## Timing
- Reset values: `rx_data`=0, `rx_data_valid`=0, `rx_running`=0, `rx_framing_error`=0, `rx_break`=0, `num_bytes_received`=0. FSM in WAIT_IDLE, shift register 0.
- Reset takes effect immediately, including mid-byte. Any partial byte is discarded, and reception restarts only after the line is seen high.
- Edge latency: `uart_rx` falls → `rx_running` high 3 clocks later (2 synchroniser flops + IDLE register).
- Let C0 be the cycle IDLE sees `rxs`=0.
  - Start sample: C0+1+HALF.
  - Data bit i sample: start sample + (i+1)·UART_CLK_TICKS_PER_BIT.
  - Stop sample: start sample + 9·UART_CLK_TICKS_PER_BIT.
  - Output pulse: registered, one cycle after the stop sample. At default this is C0+619.
- Back-to-back frames: IDLE is re-entered about 1/2 bit before the next start edge, so no frames are lost at full rate.
- A single-cycle glitch on any one of the three majority samples does not change the bit.
- The start-edge search is armed only in IDLE. Edges in other states are ignored.

## Test plan
- Byte 0x55 at 65 ticks/bit after reset → one `rx_data_valid` pulse with `rx_data`=0x55 and `num_bytes_received`=1. Pulse lands 619±2 cycles after the falling edge enters IDLE.
- Line low for 10 clocks, then high → no valid or error pulse; `rx_running` rises, then falls at the start sample; count stays 0.
- Byte 0xA5 with stop bit forced low, after a good 0x3C → `rx_framing_error` pulses once; `rx_data` stays 0x3C; count unchanged; `rx_break`=0.
- Line low for 20 bit times, then idle, then 0x31 → framing-error pulse; `rx_break` high until the line rises; then 0x31 is accepted and the count increments.
- Drive with `debugger` (DATA_WIDTH=1072, same tick parameters) sending "brR L-7766…10" → 134 valid pulses; bytes match the string in transmit order; count=134.
- Assert `reset` low mid-byte (bit 4 of 0xFF), release while the line is high → all outputs 0 immediately; next byte 0x0F is received correctly and the count is 1.
- Single-clock high pulse at the centre of data bit 2 of 0x00 → `rx_data`=0x00 (majority vote rejects the glitch).
